// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shared iterative shift-and-add multiplier with round-robin arbitration.
//
// Two requesters present unsigned operands over valid/ready handshakes. The engine
// adds one partial product per cycle, so it needs n cycles per operation. The full
// m+n bit product returns on a valid/ready response port, tagged with the ID of the
// requester that owns it. Only one operation is in flight at a time.
//
// Parameters:
//   m - multiplicand width
//   n - multiplier width, which is also the iteration count
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req0_valid/ready/a/b      requester 0 operand handshake
//   req1_valid/ready/a/b      requester 1 operand handshake
//   resp_valid/ready          product handshake
//   resp_id                   requester that owns resp_p
//   resp_p                    unsigned product a*b (m+n bits)
//   busy                      engine occupied (not idle)
module mult_share_ctrl #(
  parameter int unsigned m = 8,
  parameter int unsigned n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [m-1:0]   req0_a,
  input  logic [n-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [m-1:0]   req1_a,
  input  logic [n-1:0]   req1_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [m+n-1:0] resp_p,
  output logic           busy
);

  localparam int unsigned PW   = m + n;
  // One spare bit so the counter can represent n without wrapping.
  localparam int unsigned CntW = $clog2(n) + 1;
  localparam int unsigned IdxW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(n - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [n-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic            last_q, last_d;

  logic            gnt0, gnt1;
  logic [IdxW-1:0] bit_idx;

  // Round-robin grant: a lone requester always wins; on a tie the requester that was
  // not served last wins. Built only from valids and last_q, never from the other ready.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_q);
    gnt1 = req1_valid && (!req0_valid || !last_q);
  end

  // Ready is forced low while reset is asserted so nothing appears accepted that the
  // reset is about to discard.
  always_comb begin
    req0_ready = !rst && (state_q == StIdle) && gnt0;
    req1_ready = !rst && (state_q == StIdle) && gnt1;
  end

  assign bit_idx = cnt_q[IdxW-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (req1_ready) begin
          state_d = StRun;
          a_d     = {{n{1'b0}}, req1_a};
          b_d     = req1_b;
          id_d    = 1'b1;
          last_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (req0_ready) begin
          state_d = StRun;
          a_d     = {{n{1'b0}}, req0_a};
          b_d     = req0_b;
          id_d    = 1'b0;
          last_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end

      StRun: begin
        // No early exit on zero operands: every operation takes exactly n cycles.
        if (b_q[bit_idx]) begin
          acc_d = acc_q + (a_q << cnt_q);
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Response outputs decode straight from flops; acc and id are frozen in DONE, so
  // the response stays stable under backpressure.
  always_comb begin
    resp_valid = (state_q == StDone);
    resp_p     = acc_q;
    resp_id    = id_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: table of single operations plus hand-written
// sequences for reset, contention, backpressure and reset during RUN.
module tb_mult_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [7:0]  req0_a = '0;
  logic [7:0]  req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [7:0]  req1_a = '0;
  logic [7:0]  req1_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_id;
  logic [15:0] resp_p;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_share_ctrl #(
    .m(8),
    .n(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_p    (resp_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on a single port with resp_ready held high.
  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string tag);
    int guard;
    int cyc;
    resp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    guard = 0;
    while (!(id ? req1_ready : req0_ready) && guard < 20) begin
      step();
      guard++;
    end
    check({tag, "_ready"}, {31'b0, id ? req1_ready : req0_ready}, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check({tag, "_busy_run"}, {31'b0, busy}, 1);
    cyc = 0;
    while (!resp_valid && cyc < 30) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_p"}, {16'b0, resp_p}, {16'b0, exp});
    check({tag, "_id"}, {31'b0, resp_id}, {31'b0, id});
    step();
    check({tag, "_busy_after"}, {31'b0, busy}, 0);
    check({tag, "_valid_after"}, {31'b0, resp_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int guard;
    int cyc;
    int ng, nr, both, seen;
    int gid[8];
    int gcy[8];
    int rp[8];
    int rid[8];
    int rcy[8];

    vecs[0] = '{id: 1'b0, a: 8'd12,  b: 8'd63,  p: 16'd756};
    vecs[1] = '{id: 1'b0, a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[2] = '{id: 1'b0, a: 8'd0,   b: 8'd200, p: 16'd0};
    vecs[3] = '{id: 1'b0, a: 8'd1,   b: 8'd128, p: 16'd128};
    vecs[4] = '{id: 1'b1, a: 8'd200, b: 8'd3,   p: 16'd600};
    vecs[5] = '{id: 1'b1, a: 8'd171, b: 8'd205, p: 16'd35055};
    vecs[6] = '{id: 1'b0, a: 8'd255, b: 8'd1,   p: 16'd255};

    // Reset with both requesters asserting.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
    req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd4;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_req0_ready", {31'b0, req0_ready}, 0);
      check("rst_req1_ready", {31'b0, req1_ready}, 0);
      check("rst_resp_valid", {31'b0, resp_valid}, 0);
      check("rst_resp_p", {16'b0, resp_p}, 0);
      check("rst_resp_id", {31'b0, resp_id}, 0);
      check("rst_busy", {31'b0, busy}, 0);
    end
    rst = 1'b0;
    #1;
    check("first_tie_req0_ready", {31'b0, req0_ready}, 1);
    check("first_tie_req1_ready", {31'b0, req1_ready}, 0);
    // Withdraw both before the edge: no handshake.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("withdraw_req0_ready", {31'b0, req0_ready}, 0);
    step();
    check("withdraw_busy", {31'b0, busy}, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Backpressure: 10*20 held in DONE while req1 waits.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd20;
    #1;
    guard = 0;
    while (!req0_ready && guard < 20) begin
      step();
      guard++;
    end
    check("bp_req0_ready", {31'b0, req0_ready}, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6;
    cyc = 0;
    while (!resp_valid && cyc < 30) begin
      step();
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, resp_valid}, 1);
      check("bp_p", {16'b0, resp_p}, 200);
      check("bp_id", {31'b0, resp_id}, 0);
      check("bp_req0_ready_low", {31'b0, req0_ready}, 0);
      check("bp_req1_ready_low", {31'b0, req1_ready}, 0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_still_valid", {31'b0, resp_valid}, 1);
    step();
    resp_ready = 1'b0;
    #1;
    check("bp_idle_busy", {31'b0, busy}, 0);
    check("bp_next_accept", {31'b0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    check("bp_next_busy", {31'b0, busy}, 1);
    cyc = 0;
    while (!resp_valid && cyc < 30) begin
      step();
      cyc++;
    end
    check("bp_next_p", {16'b0, resp_p}, 30);
    check("bp_next_id", {31'b0, resp_id}, 1);
    resp_ready = 1'b1;
    step();

    // Contention from a fresh reset: both valid continuously.
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd5;
    req1_valid = 1'b1; req1_a = 8'd7; req1_b = 8'd9;
    for (int i = 0; i < 8; i++) begin
      gid[i] = -1; gcy[i] = -1; rp[i] = -1; rid[i] = -1; rcy[i] = -1;
    end
    ng = 0; nr = 0; both = 0;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if (req0_ready && ng < 8) begin
        gid[ng] = 0; gcy[ng] = c; ng++;
      end else if (req1_ready && ng < 8) begin
        gid[ng] = 1; gcy[ng] = c; ng++;
      end
      if (resp_valid && resp_ready && nr < 8) begin
        rp[nr] = int'(resp_p); rid[nr] = int'(resp_id); rcy[nr] = c; nr++;
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("cont_both_ready", both, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_grant%0d_id", i), gid[i], i % 2);
      check($sformatf("cont_grant%0d_cycle", i), gcy[i], 10 * i);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cont_resp%0d_p", i), rp[i], (i % 2 == 0) ? 15 : 63);
      check($sformatf("cont_resp%0d_id", i), rid[i], i % 2);
      check($sformatf("cont_resp%0d_cycle", i), rcy[i], 9 + 10 * i);
    end

    // Reset during RUN discards the operation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd100;
    #1;
    check("mid_req0_ready", {31'b0, req0_ready}, 1);
    step();
    req0_valid = 1'b0;
    step();
    step();
    step();
    check("mid_busy_before", {31'b0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy_after", {31'b0, busy}, 0);
    check("mid_p_after", {16'b0, resp_p}, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) seen++;
      step();
    end
    check("mid_no_response", seen, 0);
    do_op(1'b1, 8'd2, 8'd2, 16'd4, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Shared-multiplier controller. Two requesters share one iterative shift-and-add multiplier engine, and this block arbitrates between them round-robin. It accepts operands over valid/ready handshakes and runs the engine one multiplier bit per cycle. It returns the full-width product, tagged with the requester ID, over a valid/ready response port. It sits between the datapath clients and the multiplier resource, replacing single-cycle unrolled multipliers where area matters more than latency.

## Interface
- m, 8, width of multiplicand A
- n, 8, width of multiplier B; also the iteration count

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  m  requester 0 multiplicand
- req0_b  in  n  requester 0 multiplier
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a  in  m  requester 1 multiplicand
- req1_b  in  n  requester 1 multiplier
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_id  out  1  requester that owns resp_p
- resp_p  out  m+n  unsigned product A*B
- busy  out  1  engine occupied (state != IDLE)

## Operation
- Operands are unsigned. Products are exact in m+n bits; no overflow is possible.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant rule: if only one reqX_valid is high, grant it. If both are high, grant the requester that was not granted last. `last` resets to 1, so req0 wins the first tie.
  - reqX_ready = (state==IDLE) && grant==X. This is combinational from state and valids. It must not depend on reqX_ready of the other port.
  - On handshake: latch a_reg={n'b0,A}, b_reg=B, id=X, acc=0, cnt=0, last=X; go to RUN.
- RUN:
  - Each cycle: if b_reg[cnt], then acc = acc + (a_reg << cnt). Then cnt = cnt + 1.
  - After the cycle with cnt==n-1, go to DONE.
  - Every operation takes exactly n RUN cycles. There is no early termination on zero operands.
- DONE:
  - resp_valid=1; resp_p=acc; resp_id=id. All are held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
- A new request is never accepted in DONE or RUN. Both ready outputs are 0 outside IDLE.
- Requester valids that drop before handshake are legal. Grant is re-evaluated every IDLE cycle.
- cnt width is clog2(n) plus 1 bit. It must not wrap before reaching n-1.

## Timing
- Reset (rst high at edge):
  - state=IDLE, acc=0, cnt=0, id=0, last=1.
  - Outputs: resp_valid=0, resp_p=0, resp_id=0, busy=0, req0_ready=req1_ready=0 while rst is high.
- Reset has priority over every other event, including mid-RUN and DONE. The in-flight operation is discarded, with no response.
- Latency:
  - Handshake at edge k; RUN spans edges k+1..k+n.
  - resp_valid rises after edge k+n and is visible in cycle k+n.
- Throughput:
  - With resp_ready held high: one product per n+2 cycles (1 accept + n RUN + 1 DONE).
  - Earliest next accept is the cycle after the response handshake.
- resp_valid, resp_p and resp_id are registered outputs. reqX_ready is combinational.
- Simultaneous events:
  - Both valids in the same IDLE cycle: exactly one ready is high, per round-robin.
  - resp_ready high on the first DONE cycle: DONE lasts one cycle.

## Test plan
- Reset then idle: hold rst 2 cycles with both valids high. Require both readys=0, resp_valid=0, resp_p=0, busy=0. After rst falls with req0_valid=1, req0_ready=1 in the first cycle.
- Single op: req0 A=12, B=63, resp_ready=1. Require resp_valid in cycle k+8 with resp_p=756 and resp_id=0, then busy=0 in the next cycle.
- Extremes: A=255, B=255 gives 65025. A=0, B=200 gives 0 after the full 8 RUN cycles. A=1, B=128 gives 128.
- Contention: both valid continuously with distinct operands (req0 3×5, req1 7×9). Require grants in the order 0,1,0,1. Require responses in the order (15,id0), (63,id1), (15,id0), with n+2 cycle spacing.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE. Require resp_valid, resp_p and resp_id stable, and both readys=0. Then pulse resp_ready; require IDLE and a new accept on the next cycle.
- Reset mid-RUN: assert rst at RUN cycle 4 of A=100, B=100. Require no response. Then the next req1 op 2×2 returns 4 with id=1.
